// File: rtl/rl_sched_pkg.sv
// Shared types and constants for the RL period scheduler.
// Field positions locate the address nibbles and data byte in a requester word.
package rl_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_NUM_PERIODI = 10;
    localparam int DEF_N_REQ       = 4;

    localparam int NIB_HI_LSB = 12;
    localparam int NIB_LO_LSB = 8;
    localparam int BYTE_LSB   = 0;

endpackage

// File: rtl/rl_period_scheduler_if.sv
// Requester-side bundle of the RL period scheduler.
// The master drives requests and words; the slave is the scheduler.
interface rl_period_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    x;
    logic [16*N_REQ-1:0] d_flat;
    logic [N_REQ-1:0]    ack;
    logic [3:0]          a3_a0;
    logic [7:0]          z7_z0;
    logic                valid;
    logic [2:0]          owner;

    modport master (
        output req, x, d_flat,
        input  ack, a3_a0, z7_z0, valid, owner
    );

    modport slave (
        input  req, x, d_flat,
        output ack, a3_a0, z7_z0, valid, owner
    );
endinterface

// File: rtl/rl_rr_pick.sv
// Combinational winner selection for the RL period scheduler.
// RL_SCHED_FIXED_PRIO_EN selects lowest-index priority and drops the pointer.
module rl_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifndef RL_SCHED_FIXED_PRIO_EN
    input  logic [PW-1:0]    ptr,
`endif
    output logic [PW-1:0]    win,
    output logic             any
);
    assign any = |req;

`ifdef RL_SCHED_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win = PW'(i);
        end
    end
`else
    logic [PW:0] idx;
    logic        found;

    // Scan from the pointer upward, wrapping modulo N_REQ.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
            if (!found && req[idx[PW-1:0]]) begin
                win   = idx[PW-1:0];
                found = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/rl_period_scheduler.sv
// Arbitrated period-based output stage in front of the RL output interface.
// Define RL_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module rl_period_scheduler
    import rl_sched_pkg::*;
#(
    parameter int NUM_PERIODI = DEF_NUM_PERIODI,
    parameter int N_REQ       = DEF_N_REQ
) (
    input logic clock,
    input logic reset,
    rl_period_scheduler_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(NUM_PERIODI);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [3:0]       a_q, a_d;
    logic [7:0]       z_q, z_d;
    logic             valid_q, valid_d;
    logic [2:0]       owner_q, owner_d;
    logic [PW-1:0]    win;
    logic             any;
    logic             load;
    logic [15:0]      word;

    assign word = 16'(bus.d_flat >> {win, 4'b0000});

`ifndef RL_SCHED_FIXED_PRIO_EN
    logic [PW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load) ptr_d = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
    end
`endif

    rl_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req (bus.req),
`ifndef RL_SCHED_FIXED_PRIO_EN
        .ptr (ptr_q),
`endif
        .win (win),
        .any (any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            a_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            a_q     <= a_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        a_d     = a_q;
        z_d     = z_q;
        valid_d = valid_q;
        owner_d = owner_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: load = any;
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (any) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    a_d     = '0;
                    z_d     = '0;
                end
            end
        endcase
        // A period end with a pending request reloads on the same edge.
        if (load) begin
            state_d = HOLD;
            cnt_d   = CW'(NUM_PERIODI - 1);
            ack_d   = N_REQ'(1) << win;
            a_d     = bus.x[win] ? word[NIB_LO_LSB +: 4] : word[NIB_HI_LSB +: 4];
            z_d     = word[BYTE_LSB +: 8];
            valid_d = 1'b1;
            owner_d = 3'(win);
        end
    end

    assign bus.ack   = ack_q;
    assign bus.a3_a0 = a_q;
    assign bus.z7_z0 = z_q;
    assign bus.valid = valid_q;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_rl_period_scheduler.sv
// Bench for rl_period_scheduler: directed scenarios plus random traffic
// checked each cycle against a period-counting reference model.
module tb_rl_period_scheduler;
    localparam int NP = 10;
    localparam int NR = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rl_period_scheduler_if #(.N_REQ(NR)) bus();

    rl_period_scheduler #(.NUM_PERIODI(NP), .N_REQ(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: remaining cycles of the current period, 0 when idle.
    int          m_rem = 0;
    int          m_ptr = 0;
    int          m_owner = 0;
    logic [3:0]  m_ack = '0;
    logic [3:0]  m_a = '0;
    logic [7:0]  m_z = '0;
    int          g;
    logic [15:0] w;

    function automatic int pick(input logic [NR-1:0] r, input int p);
`ifdef RL_SCHED_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return 0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rem = 0; m_ptr = 0; m_owner = 0;
            m_ack = '0; m_a = '0; m_z = '0;
        end else begin
            m_ack = '0;
            if (m_rem > 1) begin
                m_rem = m_rem - 1;
            end else if (bus.req != '0) begin
                g = pick(bus.req, m_ptr);
                w = 16'(bus.d_flat >> (16 * g));
                m_a = bus.x[g] ? w[11:8] : w[15:12];
                m_z = w[7:0];
                m_owner = g;
                m_ack = 4'(1 << g);
                m_rem = NP;
                m_ptr = (g + 1) % NR;
            end else begin
                m_rem = 0; m_a = '0; m_z = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        chk("ack", 32'(bus.ack), 32'(m_ack));
        chk("a3_a0", 32'(bus.a3_a0), 32'(m_a));
        chk("z7_z0", 32'(bus.z7_z0), 32'(m_z));
        chk("valid", 32'(bus.valid), 32'(m_rem != 0));
        chk("owner", 32'(bus.owner), 32'(m_owner));
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    int owners[$];
    int low_cnt;

    initial begin
        bus.req = '0;
        bus.x = '0;
        bus.d_flat = '0;
        repeat (3) @(negedge clock);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_a", 32'(bus.a3_a0), 0);
        chk("rst_owner", 32'(bus.owner), 0);
        reset = 1'b0;

        // Single grant, high nibble then low nibble.
        for (int xs = 0; xs < 2; xs++) begin
            bus.req = 4'b0001;
            bus.x = 4'(xs);
            bus.d_flat[15:0] = 16'hA5C3;
            step();
            chk("t1_ack", 32'(bus.ack), 1);
            chk("t1_a", 32'(bus.a3_a0), xs == 0 ? 32'hA : 32'h5);
            chk("t1_z", 32'(bus.z7_z0), 32'hC3);
            bus.req = '0;
            repeat (9) begin
                step();
                chk("t1_hold", 32'(bus.valid), 1);
            end
            step();
            chk("t1_end_valid", 32'(bus.valid), 0);
            chk("t1_end_a", 32'(bus.a3_a0), 0);
            chk("t1_end_z", 32'(bus.z7_z0), 0);
            step();
        end

        // Continuous requests from everyone.
        pulse_reset();
        bus.req = 4'b1111;
        low_cnt = 0;
        repeat (50) begin
            step();
            if (bus.ack != '0) owners.push_back(int'(bus.owner));
            if (!bus.valid) low_cnt++;
        end
        chk("rr_acks", 32'(owners.size()), 5);
        chk("rr_gaps", 32'(low_cnt), 0);
        for (int i = 0; i < owners.size(); i++) begin
`ifdef RL_SCHED_FIXED_PRIO_EN
            chk("rr_owner", 32'(owners[i]), 0);
`else
            chk("rr_owner", 32'(owners[i]), 32'(i % NR));
`endif
        end
        bus.req = '0;
        repeat (12) step();

        // Request arriving on the period-end edge.
        bus.req = 4'b0001;
        step();
        chk("b2b_ack0", 32'(bus.ack), 1);
        bus.req = '0;
        repeat (9) step();
        bus.req = 4'b0100;
        step();
        chk("b2b_ack", 32'(bus.ack), 4);
        chk("b2b_owner", 32'(bus.owner), 2);
        chk("b2b_valid", 32'(bus.valid), 1);
        bus.req = '0;
        repeat (11) step();

        // Word changes during a period are ignored.
        bus.req = 4'b0010;
        bus.x = '0;
        bus.d_flat[31:16] = 16'h1234;
        step();
        chk("hold_a0", 32'(bus.a3_a0), 1);
        bus.req = '0;
        repeat (5) begin
            bus.d_flat = {$urandom, $urandom};
            bus.x = 4'($urandom);
            step();
            chk("hold_a", 32'(bus.a3_a0), 1);
            chk("hold_z", 32'(bus.z7_z0), 32'h34);
        end
        repeat (6) step();

        // Asynchronous reset in the middle of a period.
        bus.req = 4'b0001;
        bus.x = '0;
        bus.d_flat[15:0] = 16'hA5C3;
        step();
        bus.req = '0;
        repeat (4) step();
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(bus.valid), 0);
        chk("async_a", 32'(bus.a3_a0), 0);
        chk("async_z", 32'(bus.z7_z0), 0);
        chk("async_ack", 32'(bus.ack), 0);
        @(negedge clock);
        reset = 1'b0;
        bus.req = 4'b0010;
        step();
        chk("post_rst_owner", 32'(bus.owner), 1);
        chk("post_rst_ack", 32'(bus.ack), 2);
        bus.req = '0;

        // Random traffic, occasionally idle.
        repeat (400) begin
            bus.req = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
            bus.x = 4'($urandom);
            bus.d_flat = {$urandom, $urandom};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rl_period_scheduler.md
# rl_period_scheduler

Round-robin scheduler that shares one period-based output stage between `N_REQ` requesters. Each requester presents an `x` select bit and a 16-bit word. The block grants one requester per output period and drives the selected 4-bit address nibble and 8-bit data byte for exactly `NUM_PERIODI` clocks. It sits in front of the RL output interface and replaces per-source output logic with one sequenced, arbitrated stage.

## Interface
- `NUM_PERIODI`, 10: output period length in clocks; legal range 2..255.
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: reset is asynchronous and active-high; it clears all state immediately.
- `req`  in  N_REQ: per-requester request, level-sensitive.
- `x`  in  N_REQ: per-requester nibble select.
- `d_flat`  in  16*N_REQ: per-requester word; requester i occupies bits [16i+15:16i].
- `ack`  out  N_REQ: one-hot, one-cycle grant pulse.
- `a3_a0`  out  4: address nibble for the current period.
- `z7_z0`  out  8: data byte for the current period.
- `valid`  out  1: high while a period is active.
- `owner`  out  3: index of the current period's owner; only the low $clog2(N_REQ) bits are meaningful, and upper bits are 0.

## Operation
- States: IDLE, HOLD. The encoding is shared through the package.
- Reset values: state=IDLE, `ack`=0, `a3_a0`=0, `z7_z0`=0, `valid`=0, `owner`=0, round-robin pointer=0, count=0.
- A load happens on any edge where the block is in IDLE or ending a period, and `req` is non-zero. On that edge:
  - g = arbitration winner.
  - `a3_a0` <= (`x`[g]==0) ? d_g[15:12] : d_g[11:8].
  - `z7_z0` <= d_g[7:0].
  - `owner` <= g, `ack` <= one-hot(g), `valid` <= 1.
  - count <= NUM_PERIODI-1, pointer <= (g+1) mod N_REQ, state <= HOLD.
- Data and `x` are sampled only on the load edge. Later changes do not affect the current period.
- HOLD:
  - `ack` returns to 0 on the next edge.
  - If count != 0, count decrements.
  - If count == 0 the period ends. If `req` is non-zero, a load happens on that same edge (back-to-back, no idle cycle). Otherwise `valid`, `a3_a0` and `z7_z0` clear to 0, state goes to IDLE, and `owner` holds its value.
- Round-robin winner: the first set `req` bit at or after the pointer, wrapping modulo N_REQ.
- Handshake:
  - A requester holds `req` until it sees `ack`.
  - `req` still high one cycle after `ack` counts as a new request.
  - Dropping `req` before grant withdraws it with no side effect.
- Count width is $clog2(NUM_PERIODI); no wrap occurs within legal range.

## Timing
- Load latency: `req` high before edge t0 gives `ack`, `valid` and outputs updated after t0.
- `valid` stays high for exactly NUM_PERIODI cycles per grant. With continuous requests, periods abut with `valid` never low.
- `ack` is high for exactly one cycle, aligned with the first cycle of the period.
- Reset asserted mid-period: outputs go to reset values without waiting for a clock edge. After reset deasserts, the first edge sees IDLE and the pointer at 0.
- A `req` edge coinciding with the period-end edge is honoured on that edge.

## Configuration
- `RL_SCHED_FIXED_PRIO_EN` defined: fixed priority, lowest index wins, and the pointer register is not built.
- Undefined (default): round-robin as above.
- Both variants share the same ports and timing.

## Structure
- Package `rl_sched_pkg` holds:
  - the state enum (IDLE, HOLD);
  - default `NUM_PERIODI` (10) and `N_REQ` (4);
  - constants for nibble and byte field positions within the 16-bit word.
- Sub-module `rl_rr_pick`: combinational winner selection. Inputs are `req` and the pointer; outputs are the winner index and an any-request flag. It contains the fixed-priority variant under the macro.

## Test plan
- Reset then `req`=0001, d0=0xA5C3, x0=0 → after next edge: `ack`=0001, `a3_a0`=0xA, `z7_z0`=0xC3, `valid`=1 for 10 cycles, then all 0 in IDLE.
- Same stimulus with x0=1 → `a3_a0`=0x5.
- `req`=1111 held continuously → owners 0,1,2,3,0 on consecutive 10-cycle periods; `valid` never drops; one `ack` per period. With the macro defined, owner stays 0.
- `req`=0100 arriving exactly on a period-end edge → back-to-back grant with owner=2 and no idle cycle.
- d_flat changed during HOLD → `a3_a0` and `z7_z0` are unchanged until the next load.
- Reset asserted at cycle 5 of a period, between edges → outputs are 0 immediately. After release with `req`=0010, owner=1 (pointer was reset to 0).
